grid_writer: RTL

- Write-side owner of one 12x12 board memory. The board memory holds one 2-bit status per cell; the drawing logic reads it through a `{col[3:0], row[3:0]}` address.
- Converts local mouse clicks into ship placement and removal.
- Resolves remote shots into HIT or MISS, and reports each result back to the game logic.
- Clears the board on command.
- Sits between the mouse/game controller and the board memory's write port.

---
 rtl/warships_pkg.sv | 31 +++
 rtl/pixel_to_cell.sv | 27 ++
 rtl/grid_writer.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/warships_pkg.sv
// rtl/warships_pkg.sv - shared board geometry, cell status encoding and writer FSM states
package warships_pkg;

  typedef enum logic [1:0] {
    EMPTY  = 2'b00,
    MYSHIP = 2'b01,
    MISS   = 2'b10,
    HIT    = 2'b11
  } grid_status_t;

  localparam int GRID_ROWS           = 12;
  localparam int GRID_COLUMNS        = 12;
  localparam int GRID_ELEMENT_WIDTH  = 32;
  localparam int GRID_ELEMENT_HEIGHT = 32;
  localparam int GRID_BORDER_WIDTH   = 2;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    EVAL,
    WRITE,
    CLEAR
  } writer_state_t;

  // Address layout is {col[3:0], row[3:0]}; nibbles 12..15 are off the board.
  function automatic logic cell_in_range(input logic [7:0] addr);
    return (addr[7:4] < 4'(GRID_COLUMNS)) && (addr[3:0] < 4'(GRID_ROWS));
  endfunction

endpackage

// File: rtl/pixel_to_cell.sv
// rtl/pixel_to_cell.sv - maps a mouse pixel position onto a board cell address
module pixel_to_cell
  import warships_pkg::*;
#(
  parameter int X_POS = 0,
  parameter int Y_POS = 0
) (
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  output logic [7:0]  cell_addr,
  output logic        in_grid
);

  logic [10:0] dx;
  logic [10:0] dy;
  logic        unused_bits;

  // Pixels left of / above the origin wrap to large offsets and fall outside.
  assign dx = xpos[10:0] - 11'(X_POS);
  assign dy = ypos[10:0] - 11'(Y_POS);

  assign in_grid   = (dx[10:5] < 6'(GRID_COLUMNS)) && (dy[10:5] < 6'(GRID_ROWS));
  assign cell_addr = {dx[8:5], dy[8:5]};

  assign unused_bits = ^{xpos[11], ypos[11], dx[4:0], dy[4:0]};

endmodule

// File: rtl/grid_writer.sv
// rtl/grid_writer.sv - board memory write-side owner: ship placement, shot resolution, clear
module grid_writer
  import warships_pkg::*;
#(
  parameter int X_POS          = 0,
  parameter int Y_POS          = 0,
  parameter int MAX_SHIP_CELLS = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  input  logic        mouse_left,
  input  logic        place_en,
  input  logic        clear,
  input  logic        shot_valid,
  input  logic [7:0]  shot_addr,
  output logic        shot_ready,
  output logic        shot_done,
  output logic        shot_hit,
  output logic [7:0]  mem_addr,
  input  logic [1:0]  mem_rdata,
  output logic [1:0]  mem_wdata,
  output logic        mem_we,
  output logic [4:0]  ship_cells,
  output logic        busy
);

  localparam logic [4:0] MAX_CELLS = 5'(MAX_SHIP_CELLS);

  writer_state_t state;
  grid_status_t  rdata_q;
  logic          mouse_prev;
  logic          clear_pend;
  logic          op_shot;
  logic          op_skip;
  logic [7:0]    click_addr;
  logic          click_in;
  logic          click;

  pixel_to_cell #(
    .X_POS(X_POS),
    .Y_POS(Y_POS)
  ) u_pixel_to_cell (
    .xpos     (xpos),
    .ypos     (ypos),
    .cell_addr(click_addr),
    .in_grid  (click_in)
  );

  assign click      = mouse_left && !mouse_prev;
  assign busy       = (state != IDLE);
  assign shot_ready = (state == IDLE) && !clear_pend && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rdata_q    <= EMPTY;
      mouse_prev <= 1'b0;
      clear_pend <= 1'b0;
      op_shot    <= 1'b0;
      op_skip    <= 1'b0;
      mem_addr   <= 8'h00;
      mem_wdata  <= EMPTY;
      mem_we     <= 1'b0;
      shot_done  <= 1'b0;
      shot_hit   <= 1'b0;
      ship_cells <= 5'd0;
    end else begin
      mouse_prev <= mouse_left;
      mem_we     <= 1'b0;
      shot_done  <= 1'b0;
      shot_hit   <= 1'b0;

      if (clear && state != IDLE) begin
        clear_pend <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (clear || clear_pend) begin
            state      <= CLEAR;
            clear_pend <= 1'b0;
            mem_addr   <= 8'h00;
            mem_wdata  <= EMPTY;
            mem_we     <= 1'b1;
            ship_cells <= 5'd0;
          end else if (shot_valid) begin
            state   <= READ;
            op_shot <= 1'b1;
            op_skip <= !cell_in_range(shot_addr);
            if (cell_in_range(shot_addr)) begin
              mem_addr <= shot_addr;
            end
          end else if (click && place_en && click_in) begin
            state    <= READ;
            op_shot  <= 1'b0;
            op_skip  <= 1'b0;
            mem_addr <= click_addr;
          end
        end

        READ: state <= WAIT;

        WAIT: begin
          rdata_q <= grid_status_t'(mem_rdata);
          state   <= EVAL;
        end

        EVAL: begin
          state <= WRITE;
          if (op_shot) begin
            shot_done <= 1'b1;
            if (!op_skip) begin
              case (rdata_q)
                MYSHIP: begin
                  mem_we    <= 1'b1;
                  mem_wdata <= HIT;
                  shot_hit  <= 1'b1;
                end
                EMPTY: begin
                  mem_we    <= 1'b1;
                  mem_wdata <= MISS;
                end
                default: ;
              endcase
            end
          end else begin
            case (rdata_q)
              EMPTY: begin
                if (ship_cells < MAX_CELLS) begin
                  mem_we     <= 1'b1;
                  mem_wdata  <= MYSHIP;
                  ship_cells <= ship_cells + 5'd1;
                end
              end
              MYSHIP: begin
                mem_we    <= 1'b1;
                mem_wdata <= EMPTY;
                if (ship_cells != 5'd0) begin
                  ship_cells <= ship_cells - 5'd1;
                end
              end
              default: ;
            endcase
          end
        end

        WRITE: state <= IDLE;

        // mem_wdata stays EMPTY from entry; one address per cycle through 255.
        CLEAR: begin
          if (mem_addr == 8'hFF) begin
            state <= IDLE;
          end else begin
            mem_addr <= mem_addr + 8'd1;
            mem_we   <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
